bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and master multiplexer for the shared system bus. Up to four bus masters (CPU bus interfaces, DMA) raise active-low requests. The arbiter grants exactly one owner at a time and holds the grant until the owner drops its request. It then steers the owner's address, strobe, read/write and write-data onto the shared bus. It sits between the masters' bus interface blocks and the slave-side bus decoder and read-data mux.

## Interface
- `MASTER_CH`, default 4: number of masters. Fixed at 4 for this revision.
- `ADDR_W`, default 30: word address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `m_req_` in 4: per-master bus request, active-low.
- `m_grnt_` out 4: per-master grant, active-low, registered, at most one bit low.
- `m_addr` in 4×ADDR_W: per-master word address, packed with master 0 in the LSBs.
- `m_as_` in 4: per-master address strobe, active-low.
- `m_rw` in 4: per-master read/write, using the READ/WRITE encoding.
- `m_wr_data` in 4×DATA_W: per-master write data, packed.
- `bus_addr` out ADDR_W: address of the current owner.
- `bus_as_` out 1: strobe of the current owner; deasserted while no owner.
- `bus_rw` out 1: rw of the current owner; READ while no owner.
- `bus_wr_data` out DATA_W: write data of the current owner.
- `bus_owner` out 2: index of the current or last owner, for debug and read-data routing.
- `bus_busy` out 1: high while any grant is active.

## Operation
- State machine states:
  - IDLE: no grant.
  - GRANT: one grant active, held by the owner in `bus_owner`.
- Transitions out of IDLE:
  - With any `m_req_` low, pick a winner by round-robin, starting the search at `bus_owner+1` mod 4.
  - Assert that master's `m_grnt_`, load `bus_owner`, and go to GRANT.
- Behaviour in GRANT:
  - While `m_req_[bus_owner]` stays low, hold the grant. There is no preemption and no timeout.
  - When `m_req_[bus_owner]` goes high, release the grant on that edge.
  - If other requests are low on that same edge, grant the next winner on the same edge. The handover has zero dead cycles and the state stays GRANT.
  - If no other request is low, go to IDLE.
- Round-robin order: priority rotates. The master just released has the lowest priority.
  - Example: owner 1 releases while 0 and 2 request; 2 wins.
- Fairness: no master waits more than 3 ownership periods.
- Mux outputs are combinational from the registered grant state:
  - In GRANT: `bus_addr`/`bus_as_`/`bus_rw`/`bus_wr_data` = the owner's `m_*` inputs.
  - In IDLE: `bus_addr`=0, `bus_as_`=1, `bus_rw`=READ, `bus_wr_data`=0.
- `m_as_` from non-owners is ignored.
- Reset values:
  - State IDLE.
  - `m_grnt_`=4'b1111.
  - `bus_owner`=3. This makes master 0 the first-priority winner after reset.
  - `bus_busy`=0.
  - Mux outputs at their IDLE values.
- Reset mid-operation:
  - Grant is dropped at the reset edge and the bus strobe deasserts immediately.
  - Masters must re-request.

## Timing
- Grant latency: `m_req_` low sampled at edge N gives `m_grnt_` low after edge N. The requester sees the grant in cycle N+1.
- Release latency: `m_req_` high sampled at edge N gives `m_grnt_` high after edge N. The next grant is asserted at that same edge.
- Handover ordering: the old owner's grant deassertion and the new owner's grant assertion are visible in the same cycle. There is never more than one grant low.
- Combinational path: `m_*` → mux → `bus_*` is a single 4:1 mux level. There is no register on the shared bus signals.
- Simultaneous release and new request: when the owner releases on the same edge a new master asserts `m_req_`, the new request takes part in that edge's pick.
- Single master: a master re-requesting immediately after its own release is re-granted one cycle later, via IDLE, if no one else is waiting.
  - It is re-granted on the same edge if it never dropped `m_req_`, because ownership continues.

## Structure
Shared package (`bus.h`):
- `BUS_MASTER_CH`=4 and `BusOwnerBus` [1:0].
- Master index codes `BUS_MASTER_0..3`.
- Arbiter state codes `BUS_ARB_STATE_IDLE`/`GRANT`.
- `ENABLE_`/`DISABLE_`, `READ`/`WRITE`, and the word width macros, reused.

Sub-module: `bus_master_mux` holds the combinational 4:1 steering of addr/as_/rw/wr_data with the IDLE defaults. The arbiter FSM and round-robin pick live in `bus_arbiter`.

## Test plan
- Reset, then master 2 drops `m_req_` at cycle 1:
  - `m_grnt_`=4'b1011 from cycle 2.
  - `bus_owner`=2.
  - `bus_addr` tracks `m_addr[2]`.
  - `bus_busy`=1.
- All four masters request continuously, each releasing after 3 cycles of ownership:
  - Grant order 0,1,2,3,0.
  - Zero-cycle handovers.
  - Exactly one grant bit low in every cycle.
- Owner 1 holds for 20 cycles while 0 and 3 request:
  - No preemption.
  - On release, grant goes to 3, then 0.
- No requests:
  - `m_grnt_`=4'b1111.
  - `bus_as_`=1, `bus_rw`=READ, `bus_addr`=0 while `m_as_[*]` toggle.
- Reset asserted while master 0 owns the bus mid-write:
  - All grants high the cycle after the reset edge.
  - `bus_as_`=1.
  - After reset deasserts, master 0 re-requests and is granted first.
- Non-owner master 3 drives `m_as_`=0 and `m_addr`=30'h3FFF_FFFF while master 1 owns the bus:
  - The bus shows only master 1's values.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: master count, owner index type, arbiter state
// codes, active-low enable levels, read/write encoding and the round-robin
// pick helper used by the arbiter.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;
  localparam int WORD_ADDR_W   = 30;
  localparam int WORD_DATA_W   = 32;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_MASTER_3 = 2'd3;

  typedef enum logic {
    BUS_ARB_STATE_IDLE  = 1'b0,
    BUS_ARB_STATE_GRANT = 1'b1
  } arb_state_e;

  // Active-low enable levels and the rw encoding shared with the masters.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef struct packed {
    logic       found;
    bus_owner_t owner;
  } rr_pick_t;

  // Search active-high requests starting one past `last`, wrapping mod 4.
  // `last` itself is visited last, so the previous owner has lowest priority.
  function automatic rr_pick_t rr_pick(input logic [BUS_MASTER_CH-1:0] req,
                                       input bus_owner_t last);
    rr_pick_t   r;
    bus_owner_t idx;
    r.found = 1'b0;
    r.owner = last;
    for (int i = 1; i <= BUS_MASTER_CH; i++) begin
      idx = last + bus_owner_t'(i);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.owner = idx;
      end
    end
    return r;
  endfunction

  // Active-low one-cold grant vector for a given owner.
  function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input bus_owner_t owner);
    logic [BUS_MASTER_CH-1:0] g;
    g = '1;
    g[owner] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_master_mux.sv
// Combinational 4:1 steering of the owning master's address, strobe,
// read/write and write data onto the shared bus; idle defaults when no
// grant is active.
module bus_master_mux
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic                              grant_active_i,
  input  bus_owner_t                        owner_i,
  input  logic [BUS_MASTER_CH*ADDR_W-1:0]   m_addr_i,
  input  logic [BUS_MASTER_CH-1:0]          m_as_n_i,
  input  logic [BUS_MASTER_CH-1:0]          m_rw_i,
  input  logic [BUS_MASTER_CH*DATA_W-1:0]   m_wr_data_i,
  output logic [ADDR_W-1:0]                 bus_addr_o,
  output logic                              bus_as_n_o,
  output logic                              bus_rw_o,
  output logic [DATA_W-1:0]                 bus_wr_data_o
);

  // Select the owner's signals; non-owner strobes never reach the bus.
  always_comb begin
    bus_addr_o    = '0;
    bus_as_n_o    = DISABLE_;
    bus_rw_o      = READ;
    bus_wr_data_o = '0;
    if (grant_active_i) begin
      bus_addr_o    = m_addr_i[int'(owner_i)*ADDR_W +: ADDR_W];
      bus_as_n_o    = m_as_n_i[owner_i];
      bus_rw_o      = m_rw_i[owner_i];
      bus_wr_data_o = m_wr_data_i[int'(owner_i)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one master at a time, holds the grant
// until the owner drops its request, hands over with zero dead cycles and
// steers the owner's bus signals through bus_master_mux.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTER_CH = BUS_MASTER_CH,
  parameter int ADDR_W    = WORD_ADDR_W,
  parameter int DATA_W    = WORD_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MASTER_CH-1:0]          m_req_,
  output logic [MASTER_CH-1:0]          m_grnt_,
  input  logic [MASTER_CH*ADDR_W-1:0]   m_addr,
  input  logic [MASTER_CH-1:0]          m_as_,
  input  logic [MASTER_CH-1:0]          m_rw,
  input  logic [MASTER_CH*DATA_W-1:0]   m_wr_data,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic                          bus_as_,
  output logic                          bus_rw,
  output logic [DATA_W-1:0]             bus_wr_data,
  output bus_owner_t                    bus_owner,
  output logic                          bus_busy
);

  arb_state_e               state_q, state_d;
  bus_owner_t               owner_q, owner_d;
  logic [MASTER_CH-1:0]     grnt_q,  grnt_d;
  rr_pick_t                 pick;

  // State, owner and grant registers; reset leaves master 3 as last owner
  // so master 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_ARB_STATE_IDLE;
      owner_q <= BUS_MASTER_3;
      grnt_q  <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
    end
  end

  // Next-state logic: grant from IDLE, hold while the owner requests, and on
  // release either hand over on the same edge or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grnt_d  = grnt_q;
    pick    = rr_pick(~m_req_, owner_q);
    case (state_q)
      BUS_ARB_STATE_IDLE: begin
        if (pick.found) begin
          state_d = BUS_ARB_STATE_GRANT;
          owner_d = pick.owner;
          grnt_d  = grant_vec(pick.owner);
        end
      end
      BUS_ARB_STATE_GRANT: begin
        // The owner's own request is high here, so it cannot be re-picked.
        if (m_req_[owner_q] != ENABLE_) begin
          if (pick.found) begin
            owner_d = pick.owner;
            grnt_d  = grant_vec(pick.owner);
          end else begin
            state_d = BUS_ARB_STATE_IDLE;
            grnt_d  = '1;
          end
        end
      end
    endcase
  end

  assign m_grnt_   = grnt_q;
  assign bus_owner = owner_q;
  assign bus_busy  = (state_q == BUS_ARB_STATE_GRANT);

  bus_master_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .grant_active_i (bus_busy),
    .owner_i        (owner_q),
    .m_addr_i       (m_addr),
    .m_as_n_i       (m_as_),
    .m_rw_i         (m_rw),
    .m_wr_data_i    (m_wr_data),
    .bus_addr_o     (bus_addr),
    .bus_as_n_o     (bus_as_),
    .bus_rw_o       (bus_rw),
    .bus_wr_data_o  (bus_wr_data)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: an ownership model derived from the
// round-robin rules is compared against the DUT every cycle, plus directed
// scenarios with literal expectations.
module tb_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      m_req_ = 4'hF;
  logic [3:0]      m_grnt_;
  logic [AW-1:0]   a [4];
  logic [DW-1:0]   wd [4];
  logic [4*AW-1:0] m_addr;
  logic [4*DW-1:0] m_wr_data;
  logic [3:0]      m_as_ = 4'hF;
  logic [3:0]      m_rw = 4'hF;
  logic [AW-1:0]   bus_addr;
  logic            bus_as_;
  logic            bus_rw;
  logic [DW-1:0]   bus_wr_data;
  logic [1:0]      bus_owner;
  logic            bus_busy;

  assign m_addr    = {a[3], a[2], a[1], a[0]};
  assign m_wr_data = {wd[3], wd[2], wd[1], wd[0]};

  bus_arbiter dut (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .bus_owner(bus_owner), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mo = 3;     // current/last owner
  bit mb = 1'b0;  // a grant is active

  function automatic int model_pick(input logic [3:0] req_n, input int last);
    for (int k = 1; k <= 4; k++)
      if (!req_n[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grnt_f(input bit busy, input int owner);
    logic [3:0] g;
    g = 4'hF;
    if (busy) g[owner] = 1'b0;
    return g;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mo <= 3;
      mb <= 1'b0;
    end else if (mb && !m_req_[mo]) begin
      mb <= 1'b1;
    end else if (model_pick(m_req_, mo) >= 0) begin
      mo <= model_pick(m_req_, mo);
      mb <= 1'b1;
    end else begin
      mb <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grnt_",     m_grnt_,     exp_grnt_f(mb, mo));
      chk("bus_owner",   bus_owner,   mo[1:0]);
      chk("bus_busy",    bus_busy,    mb);
      chk("bus_addr",    bus_addr,    mb ? a[mo] : '0);
      chk("bus_as_",     bus_as_,     mb ? m_as_[mo] : 1'b1);
      chk("bus_rw",      bus_rw,      mb ? m_rw[mo] : RD);
      chk("bus_wr_data", bus_wr_data, mb ? wd[mo] : '0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req_ = 4'hF;
    step(1);
    reset = 1'b0;
  endtask

  int cnt [4];
  int order [$];
  int last_seen;
  int g;

  initial begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = AW'(32'h0100_0000 * (i + 1) + i);
      wd[i] = 32'hA000_0000 + DW'(i);
    end
    step(2);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_grnt",  m_grnt_,  4'hF);
    chk("rst_owner", bus_owner, 2'd3);
    chk("rst_busy",  bus_busy,  1'b0);
    chk("rst_as",    bus_as_,   1'b1);

    // Master 2 requests alone.
    m_req_ = 4'b1011;
    step(1);
    #1;
    chk("t1_grnt",  m_grnt_,  4'b1011);
    chk("t1_owner", bus_owner, 2'd2);
    chk("t1_busy",  bus_busy,  1'b1);
    chk("t1_addr",  bus_addr,  a[2]);
    a[2] = 30'h0ABC_DEF0;
    #1;
    chk("t1_track", bus_addr, 30'h0ABC_DEF0);
    // Release, then re-request alone: re-granted via IDLE.
    m_req_ = 4'hF;
    step(1);
    chk("t1_rel_busy", bus_busy, 1'b0);
    chk("t1_rel_grnt", m_grnt_,  4'hF);
    m_req_ = 4'b1011;
    step(1);
    chk("t1_regrant", m_grnt_, 4'b1011);
    m_req_ = 4'hF;
    step(1);

    // All four request; each releases after 3 cycles of ownership.
    do_reset();
    m_req_ = 4'b0000;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    last_seen = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1);
      chk("t2_onehot", $countones(~m_grnt_), 1);
      g = -1;
      for (int i = 0; i < 4; i++) if (!m_grnt_[i]) g = i;
      if (g >= 0 && g != last_seen) begin
        order.push_back(g);
        last_seen = g;
      end
      for (int i = 0; i < 4; i++) begin
        if (!m_grnt_[i]) cnt[i]++; else cnt[i] = 0;
        if (cnt[i] == 3) m_req_[i] = 1'b1;
        else if (m_grnt_[i] && m_req_[i]) m_req_[i] = 1'b0;
      end
    end
    chk("t2_order_len", order.size() >= 5, 1'b1);
    if (order.size() >= 5) begin
      chk("t2_order0", order[0], 0);
      chk("t2_order1", order[1], 1);
      chk("t2_order2", order[2], 2);
      chk("t2_order3", order[3], 3);
      chk("t2_order4", order[4], 0);
    end
    m_req_ = 4'hF;
    step(2);

    // Owner 1 holds for 20 cycles while 0 and 3 wait.
    do_reset();
    m_req_ = 4'b1101;
    step(1);
    chk("t3_own1", bus_owner, 2'd1);
    m_req_ = 4'b0100;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(1);
      chk("t3_hold", m_grnt_, 4'b1101);
    end
    m_req_ = 4'b0110;
    step(1);
    chk("t3_next3", m_grnt_, 4'b0111);
    step(2);
    m_req_ = 4'b1110;
    step(1);
    chk("t3_next0", m_grnt_, 4'b1110);
    m_req_ = 4'hF;
    step(1);
    chk("t3_idle", bus_busy, 1'b0);

    // No requests while strobes and addresses toggle.
    for (int cyc = 0; cyc < 6; cyc++) begin
      m_as_ = cyc[0] ? 4'h0 : 4'hA;
      m_rw  = 4'h0;
      a[cyc % 4] = 30'h1555_5555 ^ AW'(cyc);
      step(1);
      chk("t4_grnt", m_grnt_,  4'hF);
      chk("t4_as",   bus_as_,  1'b1);
      chk("t4_rw",   bus_rw,   RD);
      chk("t4_addr", bus_addr, 30'h0);
    end

    // Reset while master 0 owns the bus mid-write.
    do_reset();
    m_req_ = 4'b1110;
    m_as_  = 4'b1110;
    m_rw   = 4'b1110;
    wd[0]  = 32'hDEAD_BEEF;
    step(1);
    chk("t5_grnt0", m_grnt_,     4'b1110);
    chk("t5_as0",   bus_as_,     1'b0);
    chk("t5_wr",    bus_rw,      WR);
    chk("t5_wd",    bus_wr_data, 32'hDEAD_BEEF);
    reset = 1'b1;
    step(1);
    chk("t5_rst_grnt",  m_grnt_,  4'hF);
    chk("t5_rst_as",    bus_as_,  1'b1);
    chk("t5_rst_owner", bus_owner, 2'd3);
    reset = 1'b0;
    m_req_ = 4'b1100;
    step(1);
    chk("t5_regrant0", m_grnt_, 4'b1110);
    m_req_ = 4'hF;
    m_as_  = 4'hF;
    m_rw   = 4'hF;
    step(2);

    // Non-owner master 3 drives the bus signals while master 1 owns.
    do_reset();
    a[1]   = 30'h0111_1111;
    wd[1]  = 32'h1111_0000;
    m_req_ = 4'b1101;
    step(1);
    m_as_  = 4'b0111;
    m_rw   = 4'b0111;
    a[3]   = 30'h3FFF_FFFF;
    wd[3]  = 32'hFFFF_FFFF;
    #1;
    chk("t6_addr", bus_addr,    30'h0111_1111);
    chk("t6_as",   bus_as_,     1'b1);
    chk("t6_rw",   bus_rw,      RD);
    chk("t6_wd",   bus_wr_data, 32'h1111_0000);
    m_as_ = 4'b0101;
    #1;
    chk("t6_as1",  bus_as_,     1'b0);
    step(2);
    m_req_ = 4'hF;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
